// File: rtl/two_seq_det.sv
// Serial detector for overlapping 0110 / 0111 patterns with registered one-cycle match pulses.
// Optional saturating match counters are built when TWO_SEQ_DET_COUNT_EN is defined.
module two_seq_det (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       detected_0110,
  output logic       detected_0111
`ifdef TWO_SEQ_DET_COUNT_EN
  ,
  output logic [7:0] count_0110,
  output logic [7:0] count_0111
`endif
);

  // Each state names the longest received suffix that is also a prefix of 011x.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    S01  = 2'd2,
    S011 = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   det_0110_q, det_0110_d;
  logic   det_0111_q, det_0111_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    det_0110_d = 1'b0;
    det_0111_d = 1'b0;
    unique case (state_q)
      IDLE: state_d = din ? IDLE : S0;
      S0:   state_d = din ? S01  : S0;
      S01:  state_d = din ? S011 : S0;
      S011: begin
        // The trailing 0 of 0110 starts the next candidate; 0111 leaves nothing reusable.
        state_d    = din ? IDLE : S0;
        det_0110_d = ~din;
        det_0111_d = din;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TWO_SEQ_DET_COUNT_EN
  logic [7:0] cnt_0110_q, cnt_0110_d;
  logic [7:0] cnt_0111_q, cnt_0111_d;

  always_comb begin
    cnt_0110_d = cnt_0110_q;
    cnt_0111_d = cnt_0111_q;
    if (det_0110_d && (cnt_0110_q != 8'hFF)) cnt_0110_d = cnt_0110_q + 8'd1;
    if (det_0111_d && (cnt_0111_q != 8'hFF)) cnt_0111_d = cnt_0111_q + 8'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      det_0110_q <= 1'b0;
      det_0111_q <= 1'b0;
`ifdef TWO_SEQ_DET_COUNT_EN
      cnt_0110_q <= 8'd0;
      cnt_0111_q <= 8'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q    <= state_d;
      det_0110_q <= det_0110_d;
      det_0111_q <= det_0111_d;
`ifdef TWO_SEQ_DET_COUNT_EN
      cnt_0110_q <= cnt_0110_d;
      cnt_0111_q <= cnt_0111_d;
`endif
    end
  end

  assign detected_0110 = det_0110_q;
  assign detected_0111 = det_0111_q;
`ifdef TWO_SEQ_DET_COUNT_EN
  assign count_0110 = cnt_0110_q;
  assign count_0111 = cnt_0111_q;
`endif

endmodule

// File: tb/tb_two_seq_det.sv
// Self-checking bench for two_seq_det: table vectors, hand sequences and a sliding-window model.
// Counter checks are compiled in when TWO_SEQ_DET_COUNT_EN is defined.
module tb_two_seq_det;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic detected_0110;
  logic detected_0111;
`ifdef TWO_SEQ_DET_COUNT_EN
  logic [7:0] count_0110;
  logic [7:0] count_0111;
`endif

  two_seq_det dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .detected_0110(detected_0110),
    .detected_0111(detected_0111)
`ifdef TWO_SEQ_DET_COUNT_EN
    ,
    .count_0110   (count_0110),
    .count_0111   (count_0111)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;   // apply a reset before this bit
    logic       din;
    logic [1:0] exp;   // {detected_0110, detected_0111}
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_c0 = 0;
  int         m_c1 = 0;
  logic [3:0] hist = 4'd0;
  int         nbits = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_counts(input string name);
`ifdef TWO_SEQ_DET_COUNT_EN
    check({name, "_cnt0110"}, count_0110, 8'(m_c0));
    check({name, "_cnt0111"}, count_0111, 8'(m_c1));
`endif
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b0;
    #2;
    check({name, "_rst_det"}, {6'd0, detected_0110, detected_0111}, 8'd0);
    m_c0 = 0;
    m_c1 = 0;
    check_counts({name, "_rst"});
    hist  = 4'd0;
    nbits = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input logic d, input logic [1:0] exp, input string name);
    logic [1:0] e;
    din = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, {6'd0, detected_0110, detected_0111}, {6'd0, e});
    if (e[1] && m_c0 < 255) m_c0++;
    if (e[0] && m_c1 < 255) m_c1++;
    check_counts(name);
  endtask

  // Independent reference: a match is simply the last four sampled bits equal to the pattern.
  task automatic model_bit(input logic d, output logic [1:0] exp);
    hist  = {hist[2:0], d};
    nbits++;
    exp = {(nbits >= 4) && (hist == 4'b0110), (nbits >= 4) && (hist == 4'b0111)};
  endtask

  task automatic add(input logic r, input logic d, input logic [1:0] e, input string n);
    vec_t v;
    v.rst = r; v.din = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0] e;
    logic       b;

    // First 0110 match, then 0,0,1,1,1,0 giving one 0111.
    add(1, 0, 2'b00, "a0"); add(0, 1, 2'b00, "a1"); add(0, 1, 2'b00, "a2"); add(0, 0, 2'b10, "a3");
    add(0, 0, 2'b00, "b0"); add(0, 0, 2'b00, "b1"); add(0, 1, 2'b00, "b2"); add(0, 1, 2'b00, "b3");
    add(0, 1, 2'b01, "b4"); add(0, 0, 2'b00, "b5");
    // Overlapping 0110110: two pulses three cycles apart.
    add(0, 0, 2'b00, "c0"); add(0, 1, 2'b00, "c1"); add(0, 1, 2'b00, "c2"); add(0, 0, 2'b10, "c3");
    add(0, 1, 2'b00, "c4"); add(0, 1, 2'b00, "c5"); add(0, 0, 2'b10, "c6");
    // 011110: a single 0111, no reuse.
    add(0, 0, 2'b00, "d0"); add(0, 1, 2'b00, "d1"); add(0, 1, 2'b00, "d2"); add(0, 1, 2'b01, "d3");
    add(0, 1, 2'b00, "d4"); add(0, 0, 2'b00, "d5");
    // 1111 from reset: nothing.
    add(1, 1, 2'b00, "e0"); add(0, 1, 2'b00, "e1"); add(0, 1, 2'b00, "e2"); add(0, 1, 2'b00, "e3");
    // Early bits after reset can't complete a match: 110 after reset.
    add(1, 1, 2'b00, "f0"); add(0, 1, 2'b00, "f1"); add(0, 0, 2'b00, "f2");

    apply_reset("init");
    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset(vecs[i].name);
      step(vecs[i].din, vecs[i].exp, vecs[i].name);
    end

    // Reset mid-sequence discards the 011 prefix.
    apply_reset("mid");
    step(0, 2'b00, "m0"); step(1, 2'b00, "m1"); step(1, 2'b00, "m2");
    apply_reset("mid2");
    step(0, 2'b00, "m3"); step(1, 2'b00, "m4"); step(1, 2'b00, "m5"); step(0, 2'b10, "m6");

    // Reset while a pulse is high clears it without a clock edge.
    step(1, 2'b00, "p0"); step(1, 2'b00, "p1"); step(1, 2'b01, "p2");
    reset = 1'b0;
    #2;
    check("async_clear", {6'd0, detected_0110, detected_0111}, 8'd0);
    apply_reset("async");

    // Random stream against the sliding-window model.
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom_range(0, 1));
      model_bit(b, e);
      step(b, e, "rand");
    end

`ifdef TWO_SEQ_DET_COUNT_EN
    // 300 overlapping 0110 matches: count_0110 must stick at 255.
    apply_reset("sat");
    step(0, 2'b00, "sat0");
    for (int i = 0; i < 300; i++) begin
      step(1, 2'b00, "sat1");
      step(1, 2'b00, "sat2");
      step(0, 2'b10, "sat3");
    end
    check("sat_final_0110", count_0110, 8'd255);
    check("sat_final_0111", count_0111, 8'd0);
    apply_reset("sat_clr");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
